obstacle_field: RTL and testbench

Downstream consumer of the 3-bit pseudo-random generator in the dodge game. Holds the falling-obstacle grid and converts each random value into a one-hot obstacle spawned in the top row. Shifts the grid down on a divided tick and detects collisions with the player column. Drives the generator's advance pulse and enable-low control, and feeds the display and score logic.

---
 rtl/dodge_pkg.sv | 19 +
 rtl/tick_divider.sv | 31 +++
 rtl/obstacle_field.sv | 96 +++++++++
 tb/tb_obstacle_field.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dodge_pkg.sv
// Shared types and helpers for the dodge game obstacle field.
package dodge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } field_state_t;

  // Column count is fixed by the 3-bit random source.
  localparam int COLS    = 8;
  localparam int SCORE_W = 8;

  // Turn a column number into the obstacle pattern for a single row.
  function automatic logic [7:0] onehot8(input logic [2:0] col);
    onehot8 = 8'b1 << col;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Drop-step divider: pulses tick on every TICK_DIV-th enabled cycle.
module tick_divider #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Count enabled cycles, wrapping on tick; clr forces a fresh start.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/obstacle_field.sv
// Falling-obstacle grid for the dodge game: spawns, drops, scores, detects collisions.
module obstacle_field
  import dodge_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int TICK_DIV  = 50_000_000,
  parameter int SPAWN_GAP = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2:0]             rnd,
  input  logic [2:0]             player_col,
  output logic                   next,
  output logic                   gen_state,
  output logic [ROWS*COLS-1:0]   field,
  output logic                   game_over,
  output logic [SCORE_W-1:0]     score
);

  localparam int GW = (SPAWN_GAP > 0) ? $clog2(SPAWN_GAP + 1) : 1;

  field_state_t    state, state_nxt;
  logic [GW-1:0]   gap_cnt;
  logic [COLS-1:0] bottom_row;
  logic [COLS-1:0] new_row0;
  logic            tick;
  logic            hit;
  logic            step;
  logic            clear_game;

  assign bottom_row = field[(ROWS-1)*COLS +: COLS];
  // A collision pre-empts any drop step in the same cycle.
  assign hit        = (state == PLAY) && bottom_row[player_col];
  assign step       = tick && !hit;
  assign clear_game = (state == IDLE) || ((state == OVER) && start);
  assign new_row0   = (gap_cnt == '0) ? onehot8(rnd) : '0;
  assign game_over  = (state == OVER);

  tick_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (state != PLAY),
    .en   (state == PLAY),
    .tick (tick)
  );

  // Game state register; generator enable follows the next state so it lines up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gen_state <= 1'b1;
    end else begin
      state     <= state_nxt;
      gen_state <= (state_nxt != PLAY);
    end
  end

  // Next-state decode: start leaves IDLE/OVER, a hit ends PLAY.
  // NOTE: the default assignment first keeps this purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = PLAY;
      PLAY:    if (hit)   state_nxt = OVER;
      OVER:    if (start) state_nxt = PLAY;
      default: state_nxt = IDLE;
    endcase
  end

  // Grid, spawn spacing, score and the generator advance pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      field   <= '0;
      score   <= '0;
      gap_cnt <= '0;
      next    <= 1'b0;
    end else begin
      next <= step;
      if (clear_game) begin
        field   <= '0;
        score   <= '0;
        gap_cnt <= '0;
      end else if (step) begin
        field <= {field[(ROWS-1)*COLS-1:0], new_row0};
        if ((bottom_row != '0) && (score != '1)) begin
          score <= score + 1'b1;
        end
        gap_cnt <= (gap_cnt == '0) ? GW'(SPAWN_GAP) : gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_obstacle_field.sv
// Self-checking bench for obstacle_field against a spec-level grid model.
module tb_obstacle_field;

  localparam int ROWS = 8;
  localparam int W    = ROWS * 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   rnd = '0;
  logic [2:0]   player_col = '0;

  logic         next_a, gen_a, go_a;
  logic [W-1:0] field_a;
  logic [7:0]   score_a;
  logic         next_b, gen_b, go_b;
  logic [W-1:0] field_b;
  logic [7:0]   score_b;

  obstacle_field #(.ROWS(ROWS), .TICK_DIV(4), .SPAWN_GAP(2)) dut_a (
    .clk(clk), .reset(reset), .start(start), .rnd(rnd), .player_col(player_col),
    .next(next_a), .gen_state(gen_a), .field(field_a), .game_over(go_a), .score(score_a)
  );

  obstacle_field #(.ROWS(ROWS), .TICK_DIV(1), .SPAWN_GAP(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .rnd(rnd), .player_col(player_col),
    .next(next_b), .gen_state(gen_b), .field(field_b), .game_over(go_b), .score(score_b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: game phase, per-row obstacle bytes, and counts of play cycles and ticks.
  int         m_state;   // 0 idle, 1 play, 2 over
  int         m_pc;      // cycles spent in play since entering
  int         m_ticks;   // drop steps taken since entering play
  int         m_score;
  bit         m_next;
  logic [7:0] m_rows [ROWS];
  int         td, sg;
  bit         sel;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] m_field();
    logic [W-1:0] f;
    for (int r = 0; r < ROWS; r++) f[r*8 +: 8] = m_rows[r];
    return f;
  endfunction

  function automatic int col_of(input logic [7:0] row);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) if (row[i]) c = i;
    return c;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
    m_score = 0;
    m_pc    = 0;
    m_ticks = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_state = 0;
    m_next  = 1'b0;
  endtask

  // One clock of game rules, using the inputs as they stand before the edge.
  task automatic model_step();
    bit tk;
    case (m_state)
      0: begin
        m_next = 1'b0;
        if (start) begin m_state = 1; model_clear(); end
      end
      1: begin
        if (m_rows[ROWS-1][player_col]) begin
          m_state = 2;
          m_next  = 1'b0;
        end else begin
          tk = ((m_pc % td) == td - 1);
          m_pc++;
          m_next = tk;
          if (tk) begin
            if (m_rows[ROWS-1] != 0 && m_score < 255) m_score++;
            for (int r = ROWS - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
            m_rows[0] = ((m_ticks % (sg + 1)) == 0) ? 8'(1 << rnd) : 8'h00;
            m_ticks++;
          end
        end
      end
      default: begin
        m_next = 1'b0;
        if (start) begin m_state = 1; model_clear(); end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] f;
    logic [7:0]   s;
    logic         n, g, o;
    f = sel ? field_b : field_a;
    s = sel ? score_b : score_a;
    n = sel ? next_b  : next_a;
    g = sel ? gen_b   : gen_a;
    o = sel ? go_b    : go_a;
    check({tag, "_field"}, f, m_field());
    check({tag, "_score"}, s, m_score[7:0]);
    check({tag, "_next"}, n, m_next);
    check({tag, "_game_over"}, o, (m_state == 2));
    check({tag, "_gen_state"}, g, (m_state != 1));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  logic [W-1:0] snap_field;
  logic [7:0]   snap_score;
  bit           found;

  initial begin
    sel = 1'b0; td = 4; sg = 2;
    model_reset();
    #12 reset = 1'b1;
    check_all("por");

    // Reset mid-play, applied between clock edges while next is high.
    start = 1'b1;
    step("t1_start");
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd = 3'($urandom_range(0, 7));
      step("t1_play");
    end
    check("t1_next_pre", next_a, 1'b1);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("t1_async_rst");
    #2 reset = 1'b1;

    // First spawn and drop cadence.
    rnd = 3'd5; player_col = 3'd0; start = 1'b1;
    step("t2_start");
    start = 1'b0;
    for (int i = 0; i < 3; i++) step("t2_wait");
    check("t2_row0_before", field_a[7:0], 8'h00);
    step("t2_spawn");
    check("t2_row0_spawn", field_a[7:0], 8'h20);
    check("t2_next_c5", next_a, 1'b1);
    step("t2_after");
    check("t2_next_c6", next_a, 1'b0);

    // Dodge run: 40 ticks in total from start, with start toggling (ignored in play).
    for (int i = 0; i < 155; i++) begin
      start = 1'($urandom_range(0, 1));
      step("t3_run");
    end
    start = 1'b0;
    check("t3_score", score_a, 8'd11);
    check("t3_game_over", go_a, 1'b0);
    check("t3_gen_state", gen_a, 1'b0);

    // Collision: step into the column-5 obstacle once it reaches the bottom row.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_rows[ROWS-1] != 0) found = 1'b1;
      else step("t4_seek");
    end
    check("t4_found", found, 1'b1);
    player_col = 3'd5;
    step("t4_hit");
    check("t4_game_over", go_a, 1'b1);
    check("t4_gen_state", gen_a, 1'b1);
    snap_field = field_a;
    for (int i = 0; i < 20; i++) begin
      rnd = 3'($urandom_range(0, 7));
      player_col = 3'($urandom_range(0, 7));
      step("t4_frozen");
    end
    check("t4_field_held", field_a, snap_field);

    // Tick and collision in the same cycle, with random spawns and a dodging player.
    start = 1'b1;
    step("t5_restart");
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      rnd = 3'($urandom_range(0, 7));
      if (m_rows[ROWS-1] != 0 && (m_pc % td) == td - 1) begin
        player_col = 3'(col_of(m_rows[ROWS-1]));
        found = 1'b1;
      end else begin
        player_col = (m_rows[ROWS-1] != 0) ? 3'((col_of(m_rows[ROWS-1]) + 1) % 8)
                                           : 3'($urandom_range(0, 7));
        step("t5_run");
      end
    end
    check("t5_found", found, 1'b1);
    snap_field = field_a;
    snap_score = score_a;
    step("t5_hit");
    check("t5_field_held", field_a, snap_field);
    check("t5_score_held", score_a, snap_score);
    check("t5_next", next_a, 1'b0);
    check("t5_game_over", go_a, 1'b1);
    step("t5_after");
    check("t5_next_after", next_a, 1'b0);

    // Saturation and restart on the fast instance.
    sel = 1'b1; td = 1; sg = 0;
    #3 reset = 1'b0;
    #1 model_reset();
    check_all("t6_rst");
    #3 reset = 1'b1;
    rnd = 3'd5; player_col = 3'd0; start = 1'b1;
    step("t6_start");
    start = 1'b0;
    for (int i = 0; i < 300; i++) step("t6_run");
    check("t6_score_sat", score_b, 8'd255);
    player_col = 3'd5;
    step("t6_hit");
    check("t6_game_over", go_b, 1'b1);
    start = 1'b1;
    step("t6_restart");
    start = 1'b0;
    check("t6_field_clr", field_b, '0);
    check("t6_score_clr", score_b, 8'd0);
    check("t6_play", gen_b, 1'b0);
    player_col = 3'd0;
    for (int i = 0; i < 10; i++) step("t6_resume");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
